// File: rtl/rvc_fetch_pkg.sv
// Shared types and constants for the RVC-aware instruction fetch aligner.

package rvc_fetch_pkg;

  localparam int unsigned ILEN = 32;
  localparam int unsigned HLEN = 16;

  // A halfword whose low two bits are not both set starts a compressed instruction.
  localparam logic [1:0] RVC_MASK = 2'b11;

  typedef enum logic [1:0] {
    S_WORD,
    S_ALIGN,
    S_HALF
  } fetch_state_e;

  function automatic logic is_rvc(input logic [HLEN-1:0] half);
    return (half[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

endpackage

// File: rtl/rvc_fetch_align.sv
// Fetches 32-bit words from the I-cache and realigns them into a stream of
// 16-bit (RVC) and 32-bit instructions, one per cycle, with a one-halfword carry buffer.

module rvc_fetch_align
  import rvc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ICACHE_ren,
  output logic [29:0]     ICACHE_addr,
  input  logic [ILEN-1:0] ICACHE_rdata,
  input  logic            ICACHE_stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  input  logic            core_stall,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [31:0]     inst_pc,
  output logic            inst_is_rvc
);

  localparam fetch_state_e RESET_STATE = RESET_PC[1] ? S_ALIGN : S_WORD;

  fetch_state_e    r_state, w_state_d;
  logic [31:0]     r_pc, w_pc_d;
  logic [HLEN-1:0] r_hbuf, w_hbuf_d;
  logic            r_valid, w_valid_d;
  logic [ILEN-1:0] r_inst, w_inst_d;
  logic [31:0]     r_inst_pc, w_inst_pc_d;
  logic            r_is_rvc, w_is_rvc_d;

  logic [HLEN-1:0] w_lo, w_hi;
  logic [31:0]     w_pc_plus2, w_pc_plus4;
  logic            w_hold, w_hbuf_rvc, w_need_fetch, w_resp;
  logic            w_unused_pc0;

  assign w_lo         = ICACHE_rdata[HLEN-1:0];
  assign w_hi         = ICACHE_rdata[ILEN-1:HLEN];
  assign w_pc_plus2   = r_pc + 32'd2;
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_hold       = r_valid & core_stall;
  assign w_hbuf_rvc   = is_rvc(r_hbuf);
  assign w_unused_pc0 = redirect_pc[0];

  // A buffered compressed instruction is issued straight from hbuf without a cache access.
  assign w_need_fetch = !((r_state == S_HALF) && w_hbuf_rvc);

  assign ICACHE_ren  = rst_n & ~redirect & ~w_hold & w_need_fetch;
  assign ICACHE_addr = (r_state == S_HALF) ? w_pc_plus2[31:2] : r_pc[31:2];
  assign w_resp      = ICACHE_ren & ~ICACHE_stall;

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_hbuf_d    = r_hbuf;
    w_valid_d   = r_valid;
    w_inst_d    = r_inst;
    w_inst_pc_d = r_inst_pc;
    w_is_rvc_d  = r_is_rvc;

    if (redirect) begin
      w_valid_d = 1'b0;
      w_pc_d    = {redirect_pc[31:1], 1'b0};
      w_state_d = redirect_pc[1] ? S_ALIGN : S_WORD;
    end else if (!w_hold) begin
      w_valid_d = 1'b0;
      case (r_state)
        S_WORD: begin
          if (w_resp) begin
            w_valid_d   = 1'b1;
            w_inst_pc_d = r_pc;
            if (is_rvc(w_lo)) begin
              w_inst_d   = {{(ILEN-HLEN){1'b0}}, w_lo};
              w_is_rvc_d = 1'b1;
              w_hbuf_d   = w_hi;
              w_pc_d     = w_pc_plus2;
              w_state_d  = S_HALF;
            end else begin
              w_inst_d   = ICACHE_rdata;
              w_is_rvc_d = 1'b0;
              w_pc_d     = w_pc_plus4;
            end
          end
        end
        S_ALIGN: begin
          if (w_resp) begin
            if (is_rvc(w_hi)) begin
              w_valid_d   = 1'b1;
              w_inst_d    = {{(ILEN-HLEN){1'b0}}, w_hi};
              w_inst_pc_d = r_pc;
              w_is_rvc_d  = 1'b1;
              w_pc_d      = w_pc_plus2;
              w_state_d   = S_WORD;
            end else begin
              // Upper half opens a 32-bit instruction: park it and fetch the rest.
              w_hbuf_d  = w_hi;
              w_state_d = S_HALF;
            end
          end
        end
        S_HALF: begin
          if (w_hbuf_rvc) begin
            w_valid_d   = 1'b1;
            w_inst_d    = {{(ILEN-HLEN){1'b0}}, r_hbuf};
            w_inst_pc_d = r_pc;
            w_is_rvc_d  = 1'b1;
            w_pc_d      = w_pc_plus2;
            w_state_d   = S_WORD;
          end else if (w_resp) begin
            w_valid_d   = 1'b1;
            w_inst_d    = {w_lo, r_hbuf};
            w_inst_pc_d = r_pc;
            w_is_rvc_d  = 1'b0;
            w_hbuf_d    = w_hi;
            w_pc_d      = w_pc_plus4;
          end
        end
        default: w_state_d = S_WORD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RESET_STATE;
      r_pc      <= RESET_PC;
      r_hbuf    <= '0;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_is_rvc  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_hbuf    <= w_hbuf_d;
      r_valid   <= w_valid_d;
      r_inst    <= w_inst_d;
      r_inst_pc <= w_inst_pc_d;
      r_is_rvc  <= w_is_rvc_d;
    end
  end

  assign inst_valid  = r_valid;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign inst_is_rvc = r_is_rvc;

endmodule

// File: tb/tb_rvc_fetch_align.sv
// Directed bench for rvc_fetch_align: a word-array I-cache model feeds the DUT and a
// scoreboard of expected (inst, pc, rvc, cycle) entries is checked as outputs are accepted.

module tb_rvc_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        core_stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_rvc;

  rvc_fetch_align dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ICACHE_ren   (ICACHE_ren),
    .ICACHE_addr  (ICACHE_addr),
    .ICACHE_rdata (ICACHE_rdata),
    .ICACHE_stall (ICACHE_stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .core_stall   (core_stall),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_is_rvc  (inst_is_rvc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign ICACHE_rdata = mem[ICACHE_addr[7:0]];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rvc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] pc, input logic rvc, input int c);
    exp_t e;
    e.inst = i;
    e.pc   = pc;
    e.rvc  = rvc;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  // Entered and left at a falling edge; samples 1 time unit later.
  task automatic step();
    exp_t e;
    #1;
    if (ICACHE_ren && !ICACHE_stall) rd_cnt++;
    if (inst_valid && !core_stall) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_out: observed inst %h pc %h, expected no output", inst, inst_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("inst", inst, e.inst);
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_is_rvc", {31'b0, inst_is_rvc}, {31'b0, e.rvc});
        chk("out_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk("sb_left", 32'(sb.size()), 32'd0);
    core_stall = 1'b1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    ICACHE_stall = 1'b0;
    #1;
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_rvc", {31'b0, inst_is_rvc}, 32'd0);
    chk("rst_ren", {31'b0, ICACHE_ren}, 32'd0);
    chk("rst_addr", {2'b0, ICACHE_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    core_stall = 1'b0;
    rst_n      = 1'b1;
    cyc        = 0;
    rd_cnt     = 0;
    sb.delete();
  endtask

  initial begin
    @(negedge clk);

    // Two back-to-back 32-bit words.
    fill_nops();
    mem[1] = 32'h0010_0093;
    do_reset();
    push(32'h0000_0013, 32'h0, 1'b0, 1);
    push(32'h0010_0093, 32'h4, 1'b0, 2);
    #1;
    chk("first_ren", {31'b0, ICACHE_ren}, 32'd1);
    chk("first_addr", {2'b0, ICACHE_addr}, 32'd0);
    drain(10);
    chk("reads_w32", 32'(rd_cnt), 32'd3);

    // Two c.li in one word: second issued from hbuf without a read.
    fill_nops();
    mem[0] = 32'h4501_4501;
    do_reset();
    push(32'h0000_4501, 32'h0, 1'b1, 1);
    push(32'h0000_4501, 32'h2, 1'b1, 2);
    drain(10);
    chk("reads_2rvc", 32'(rd_cnt), 32'd2);

    // RVC then a 32-bit instruction straddling words, leaving 0x0000 at pc 6.
    fill_nops();
    mem[0] = 32'h0093_4505;
    mem[1] = 32'h0000_0010;
    do_reset();
    push(32'h0000_4505, 32'h0, 1'b1, 1);
    push(32'h0010_0093, 32'h2, 1'b0, 2);
    push(32'h0000_0000, 32'h6, 1'b1, 3);
    drain(10);
    chk("reads_straddle", 32'(rd_cnt), 32'd3);

    // Redirect to an odd halfword address: bit0 dropped, one bubble.
    fill_nops();
    mem[8'h40] = 32'h4505_0001;
    do_reset();
    push(32'h0000_0013, 32'h0, 1'b0, 1);
    push(32'h0000_4505, 32'h102, 1'b1, 3);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_ren", {31'b0, ICACHE_ren}, 32'd0);
    step();
    redirect = 1'b0;
    drain(10);

    // core_stall for three cycles with a valid output.
    fill_nops();
    mem[1] = 32'h0010_0093;
    do_reset();
    push(32'h0000_0013, 32'h0, 1'b0, 4);
    push(32'h0010_0093, 32'h4, 1'b0, 5);
    step();
    core_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h0000_0013);
      chk("hold_pc", inst_pc, 32'h0);
      chk("hold_rvc", {31'b0, inst_is_rvc}, 32'd0);
      chk("hold_ren", {31'b0, ICACHE_ren}, 32'd0);
      step();
    end
    core_stall = 1'b0;
    drain(10);

    // I-cache stall for five cycles with a redirect in the third.
    fill_nops();
    mem[0]     = 32'h0000_4505;
    mem[8'h40] = 32'h0030_0193;
    do_reset();
    ICACHE_stall = 1'b1;
    push(32'h0030_0193, 32'h100, 1'b0, 6);
    step();
    #1;
    chk("istall_ren", {31'b0, ICACHE_ren}, 32'd1);
    chk("istall_addr", {2'b0, ICACHE_addr}, 32'd0);
    chk("istall_valid", {31'b0, inst_valid}, 32'd0);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    chk("istall_redir_ren", {31'b0, ICACHE_ren}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("istall_new_addr", {2'b0, ICACHE_addr}, 32'h40);
    step();
    step();
    ICACHE_stall = 1'b0;
    drain(10);

    // PC wraps from 0xFFFF_FFFE to 0.
    fill_nops();
    mem[8'hFF] = 32'h4505_0000;
    do_reset();
    push(32'h0000_4505, 32'hFFFF_FFFE, 1'b1, 2);
    push(32'h0000_0013, 32'h0, 1'b0, 3);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    drain(10);

    // Misaligned 32-bit instruction after a redirect to pc 2.
    fill_nops();
    mem[0] = 32'h0093_0001;
    mem[1] = 32'h4501_0010;
    do_reset();
    push(32'h0010_0093, 32'h2, 1'b0, 3);
    push(32'h0000_4501, 32'h6, 1'b1, 4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0002;
    step();
    redirect = 1'b0;
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvc_fetch_align.md
RVC_FETCH_ALIGN -- requirements
Module: rvc_fetch_align

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch PC after reset.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ICACHE_ren  out  1  word read request to the I-cache.
- ICACHE_addr  out  30  word address, PC[31:2].
- ICACHE_rdata  in  32  little-endian instruction word.
- ICACHE_stall  in  1  cache busy; data is valid in any cycle with ren=1 and stall=0.
- redirect  in  1  branch/jump redirect from the core.
- redirect_pc  in  32  redirect target; bit0 ignored.
- core_stall  in  1  core not accepting the output this cycle.
- inst_valid  out  1  inst holds a valid instruction.
- inst  out  32  instruction; an RVC instruction is zero-extended in [15:0].
- inst_pc  out  32  address of inst.
- inst_is_rvc  out  1  inst is 16-bit.

Function
REQ-003 SHALL classify a halfword as RVC iff bits[1:0] != 2'b11.
REQ-004 SHALL use a one-halfword buffer (hbuf, hbuf_pc) and a 3-state FSM:
- S_WORD: buffer empty, PC word-aligned.
- S_ALIGN: buffer empty, PC[1]=1.
- S_HALF: hbuf valid at PC.
REQ-005 S_WORD: fetch at PC.
- On a response whose low half is RVC: emit the low half, put the high half into hbuf at PC+2, go to S_HALF.
- On a 32-bit response: emit the word, PC+=4, stay in S_WORD.
REQ-006 S_ALIGN: fetch at PC and discard the low half.
- If the high half is RVC: emit it, PC+=2, go to S_WORD.
- Otherwise: store the high half in hbuf, go to S_HALF with no emit.
REQ-007 S_HALF, hbuf RVC: emit hbuf with no cache request (ICACHE_ren=0), PC+=2, go to S_WORD.
REQ-008 S_HALF, hbuf not RVC: fetch at PC+2.
- Emit {rdata[15:0], hbuf} with inst_pc=hbuf_pc.
- Put rdata[31:16] into hbuf at hbuf_pc+4 and stay in S_HALF.
REQ-009 Outputs SHALL be registered: an instruction appears one cycle after the enabling cache response.
REQ-010 While inst_valid=1 and core_stall=1, SHALL hold inst, inst_pc, inst_is_rvc, inst_valid, FSM state, PC and hbuf, and drive ICACHE_ren=0.
REQ-011 While ICACHE_stall=1, SHALL hold ICACHE_addr stable, keep ICACHE_ren=1 and emit nothing.
REQ-012 Sustained throughput with no stalls SHALL be one instruction per cycle, except the single S_ALIGN bubble.
REQ-013 Redirect SHALL have priority over every other event, including core_stall and ICACHE_stall.
- Same cycle: ICACHE_ren=0.
- Next edge: inst_valid=0, hbuf invalid, PC=redirect_pc with bit0 cleared.
- Next state: S_WORD if redirect_pc[1]=0, else S_ALIGN.
- Any response in the redirect cycle SHALL be discarded.
REQ-014 PC arithmetic SHALL be modulo 2^32 (wrap at 32'hFFFF_FFFE).

Reset
REQ-015 While rst_n=0, SHALL force:
- inst_valid=0, inst=0, inst_pc=0, inst_is_rvc=0;
- ICACHE_ren=0, ICACHE_addr=RESET_PC[31:2];
- hbuf invalid, PC=RESET_PC;
- state S_WORD, or S_ALIGN if RESET_PC[1]=1.
REQ-016 ICACHE_ren SHALL assert in the first cycle after rst_n deasserts.
REQ-017 Reset asserted mid-fetch or mid-stall SHALL abandon the fetch.

Structure
REQ-018 Package rvc_fetch_pkg SHALL hold:
- the FSM state enum;
- the RVC opcode-mask constant 2'b11;
- the instruction width 32 and halfword width 16.
REQ-019 SHALL be a single module with no sub-module; the halfword buffer and FSM are inline.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Words 0x00000013 and 0x00100093 at 0x0 and 0x4, no stalls -> inst_valid on consecutive cycles, inst_pc 0x0 then 0x4, inst_is_rvc=0.
- Word 0x45014501 at 0x0 (two c.li) -> two RVC outputs 0x00004501 at pc 0x0 and 0x2; only one cache read.
- Word 0x00934505 then 0x00000010 -> RVC 0x4505 at 0x0, then 32-bit 0x00100093 at 0x2, hbuf=0x0000 at pc 0x6.
- Redirect to 0x102 with word 0x4505xxxx at 0x100 -> one bubble, then RVC 0x4505 at pc 0x102.
- core_stall held 3 cycles with inst_valid=1 -> all outputs constant, ICACHE_ren=0; the next instruction follows one cycle after release.
- ICACHE_stall for 5 cycles followed by redirect in the 3rd -> the stalled response is discarded and the first output has inst_pc=redirect_pc.
